// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its bus monitor.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_REG       = 4'd3,
      ST_REG_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_IGNORE    = 4'd9
   } state_e;

   localparam logic       I2C_ACK             = 1'b0;
   localparam logic       I2C_NACK            = 1'b1;
   localparam logic       I2C_RW_READ         = 1'b1;
   localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h42;

   function automatic logic [7:0] next_ptr(input logic [7:0] ptr);
      return ptr + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_bus_monitor #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);
   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_hist_q;
   logic                   sda_hist_q;
   logic                   scl_s;

   // Reset to the idle-bus level so release from reset never looks like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_hist_q <= scl_s;
         sda_hist_q <= sda_s;
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_hist_q;
   assign scl_fall  = ~scl_s & scl_hist_q;
   assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
   assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address match and an auto-incrementing 8-bit register port.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0]  TARGET_ADDR = DEFAULT_TARGET_ADDR,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   input  logic [7:0] reg_rdata,
   output logic       busy
);
   logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
   state_e     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic       rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] reg_addr_q, reg_addr_d;
   logic [7:0] reg_wdata_q, reg_wdata_d;
   logic       reg_we_q, reg_we_d;
   logic       busy_q, busy_d;
   logic [7:0] byte_s;

   i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_bus_monitor (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   assign byte_s = {shift_q[6:0], sda_s};

   // State and output registers; reset releases SDA immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= 8'h00;
         bit_cnt_q   <= 4'd0;
         rw_q        <= 1'b0;
         sda_oe_q    <= 1'b0;
         reg_addr_q  <= 8'h00;
         reg_wdata_q <= 8'h00;
         reg_we_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         rw_q        <= rw_d;
         sda_oe_q    <= sda_oe_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         busy_q      <= busy_d;
      end
   end

   // Protocol sequencing; START/STOP take precedence over SCL edges.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      rw_d        = rw_q;
      sda_oe_d    = sda_oe_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      busy_d      = busy_q;
      if (start_det) begin
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         state_d   = ST_ADDR;
      end else if (stop_det) begin
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         state_d  = ST_IDLE;
      end else begin
         case (state_q)
            ST_ADDR, ST_REG, ST_WDATA: begin
               if (scl_rise) begin
                  shift_d = byte_s;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     if (state_q == ST_ADDR) begin
                        if (byte_s[7:1] == TARGET_ADDR) begin
                           busy_d  = 1'b1;
                           rw_d    = byte_s[0];
                           state_d = ST_ADDR_ACK;
                        end else begin
                           state_d = ST_IGNORE;
                        end
                     end else if (state_q == ST_REG) begin
                        reg_addr_d = byte_s;
                        state_d    = ST_REG_ACK;
                     end else begin
                        reg_wdata_d = byte_s;
                        reg_we_d    = 1'b1;
                        state_d     = ST_WDATA_ACK;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            // First fall after the byte drives ACK, the next one ends the ACK clock.
            ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     if (state_q == ST_REG_ACK) begin
                        state_d = ST_WDATA;
                     end else if (state_q == ST_WDATA_ACK) begin
                        reg_addr_d = next_ptr(reg_addr_q);
                        state_d    = ST_WDATA;
                     end else if (rw_q == I2C_RW_READ) begin
                        shift_d   = reg_rdata;
                        sda_oe_d  = ~reg_rdata[7];
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RDATA;
                     end else begin
                        state_d = ST_REG;
                     end
                  end
               end
            end
            ST_RDATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RDATA_ACK;
                  end else begin
                     sda_oe_d = ~shift_q[6];
                     shift_d  = {shift_q[6:0], 1'b0};
                  end
               end
            end
            // Pointer advances on the controller's ACK/NACK; the reload waits for the
            // following fall so reg_rdata reflects the new pointer.
            ST_RDATA_ACK: begin
               if (scl_rise) begin
                  reg_addr_d = next_ptr(reg_addr_q);
                  if (sda_s == I2C_NACK) begin
                     state_d = ST_IGNORE;
                  end else begin
                     state_d = ST_RDATA_ACK;
                  end
               end else if (scl_fall) begin
                  shift_d   = reg_rdata;
                  sda_oe_d  = ~reg_rdata[7];
                  bit_cnt_d = 4'd0;
                  state_d   = ST_RDATA;
               end
            end
            ST_IGNORE: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign sda_oe    = sda_oe_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_we    = reg_we_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench: bit-banged I2C controller plus a register-file reference model.
module tb_i2c_target;
   localparam int Q = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_drv, sda_drv;
   logic       scl_in, sda_in, sda_oe, reg_we, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;

   logic [7:0]  mem [256];
   logic [7:0]  model_mem [256];
   logic [7:0]  model_ptr;
   logic [15:0] we_log[$];
   int          oe_cnt = 0;
   int          busy_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign scl_in    = scl_drv;
   assign sda_in    = sda_drv & ~sda_oe;
   assign reg_rdata = mem[reg_addr];

   i2c_target dut (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (reg_we) we_log.push_back({reg_addr, reg_wdata});
      if (sda_oe) oe_cnt = oe_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
   end

   task automatic hq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; hq();
      scl_drv = 1'b1; hq();
      sda_drv = 1'b0; hq();
      scl_drv = 1'b0; hq();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; hq();
      scl_drv = 1'b1; hq();
      sda_drv = 1'b1; hq();
   endtask

   task automatic clock_bit(input logic b, output logic s);
      sda_drv = b;    hq();
      scl_drv = 1'b1; hq();
      s = sda_in;     hq();
      scl_drv = 1'b0; hq();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic give_ack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         b[i] = s;
      end
      clock_bit(give_ack ? 1'b0 : 1'b1, s);
   endtask

   // Copy the writes the DUT actually made into the bench register file.
   task automatic apply_writes(input int base);
      for (int i = base; i < we_log.size(); i++) mem[we_log[i][15:8]] = we_log[i][7:0];
   endtask

   task automatic do_write(input logic [7:0] r, input logic [7:0] d[$]);
      logic a0, a1, ak, dbad;
      int base;
      logic [15:0] exp;
      base = we_log.size();
      dbad = 1'b0;
      i2c_start();
      write_byte(8'h84, a0);
      write_byte(r, a1);
      foreach (d[i]) begin
         write_byte(d[i], ak);
         dbad = dbad | ak;
      end
      checks++;
      if ({a0, a1} !== 2'b00) begin
         errors++; $display("FAIL wr_addr_reg_ack got %b required 00", {a0, a1});
      end
      if (d.size() > 0) begin
         checks++;
         if (dbad !== 1'b0) begin errors++; $display("FAIL wr_data_ack got NACK required ACK"); end
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_mid got %b required 1", busy); end
      i2c_stop();
      checks++;
      if (we_log.size() - base != d.size()) begin
         errors++; $display("FAIL wr_count got %0d required %0d", we_log.size() - base, d.size());
      end else begin
         foreach (d[i]) begin
            exp = {r + 8'(i), d[i]};
            checks++;
            if (we_log[base + i] !== exp) begin
               errors++; $display("FAIL wr_event got %h required %h", we_log[base + i], exp);
            end
         end
      end
      apply_writes(base);
      foreach (d[i]) model_mem[r + 8'(i)] = d[i];
      model_ptr = r + 8'(d.size());
      checks++;
      if (reg_addr !== model_ptr) begin
         errors++; $display("FAIL wr_ptr got %h required %h", reg_addr, model_ptr);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b required 0", busy); end
   endtask

   task automatic do_read(input int n);
      logic a;
      logic [7:0] b, exp;
      i2c_start();
      write_byte(8'h85, a);
      checks++;
      if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b required 0", a); end
      for (int i = 0; i < n; i++) begin
         read_byte(i != n - 1, b);
         exp = model_mem[model_ptr + 8'(i)];
         checks++;
         if (b !== exp) begin errors++; $display("FAIL rd_data got %h required %h", b, exp); end
      end
      checks++;
      if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release got %b required 0", sda_oe); end
      i2c_stop();
      model_ptr = model_ptr + 8'(n);
      checks++;
      if (reg_addr !== model_ptr) begin
         errors++; $display("FAIL rd_ptr got %h required %h", reg_addr, model_ptr);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end got %b required 0", busy); end
   endtask

   task automatic test_reset();
      rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({sda_oe, reg_we, busy} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b required 000", {sda_oe, reg_we, busy});
      end
      checks++;
      if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h required 00", reg_addr); end
      checks++;
      if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h required 00", reg_wdata); end
      rst = 1'b0;
      model_ptr = 8'h00;
      hq();
   endtask

   task automatic test_write_single();
      logic [7:0] d[$];
      d.push_back(8'hA5);
      do_write(8'h10, d);
   endtask

   task automatic test_wrap();
      logic [7:0] d[$];
      d.push_back(8'h12);
      d.push_back(8'h34);
      do_write(8'hFF, d);
   endtask

   task automatic test_read_after_write();
      logic [7:0] none[$];
      mem[8'h20] = 8'h5A; model_mem[8'h20] = 8'h5A;
      mem[8'h21] = 8'hC3; model_mem[8'h21] = 8'hC3;
      do_write(8'h20, none);
      do_read(2);
   endtask

   task automatic test_mismatch();
      logic a, a2;
      int o0, b0, w0;
      o0 = oe_cnt; b0 = busy_cnt; w0 = we_log.size();
      i2c_start();
      write_byte(8'h86, a);
      write_byte(8'hFF, a2);
      write_byte(8'hFF, a2);
      i2c_stop();
      checks++;
      if (a !== 1'b1) begin errors++; $display("FAIL mm_ack got %b required 1", a); end
      checks++;
      if (oe_cnt != o0) begin errors++; $display("FAIL mm_sda_oe got %0d required 0 cycles", oe_cnt - o0); end
      checks++;
      if (busy_cnt != b0) begin errors++; $display("FAIL mm_busy got %0d required 0 cycles", busy_cnt - b0); end
      checks++;
      if (we_log.size() != w0) begin errors++; $display("FAIL mm_we got %0d required 0", we_log.size() - w0); end
   endtask

   task automatic test_rstart();
      logic a, s;
      logic [7:0] r;
      int w0;
      r = 8'($urandom_range(0, 255));
      w0 = we_log.size();
      i2c_start();
      write_byte(8'h84, a);
      write_byte(r, a);
      for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), s);
      model_ptr = r;
      do_read(1);
      checks++;
      if (we_log.size() != w0) begin errors++; $display("FAIL rs_we got %0d required 0", we_log.size() - w0); end
   endtask

   task automatic test_async_reset();
      logic s;
      logic [7:0] d[$];
      i2c_start();
      for (int i = 7; i >= 0; i--) clock_bit(1'((8'h84 >> i) & 8'h01), s);
      sda_drv = 1'b1; hq();
      checks++;
      if (sda_oe !== 1'b1) begin errors++; $display("FAIL ar_ack_drive got %b required 1", sda_oe); end
      @(posedge clk); #2;
      rst = 1'b1; #1;
      checks++;
      if (sda_oe !== 1'b0) begin errors++; $display("FAIL ar_release got %b required 0", sda_oe); end
      checks++;
      if ({reg_addr, busy} !== 9'h000) begin errors++; $display("FAIL ar_state got %h required 000", {reg_addr, busy}); end
      @(negedge clk); rst = 1'b0;
      model_ptr = 8'h00;
      i2c_stop();
      d.push_back(8'($urandom));
      d.push_back(8'($urandom));
      do_write(8'($urandom), d);
      do_read(2);
   endtask

   task automatic test_random();
      logic [7:0] d[$], none[$];
      logic [7:0] r;
      int n;
      for (int it = 0; it < 4; it++) begin
         r = 8'($urandom);
         n = $urandom_range(1, 4);
         d.delete();
         for (int i = 0; i < n; i++) d.push_back(8'($urandom));
         do_write(r, d);
         do_write(r, none);
         do_read(n);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         model_mem[i] = mem[i];
      end
      test_reset();
      test_write_single();
      test_wrap();
      test_read_after_write();
      test_mismatch();
      test_rstart();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) for the other end of the bus from our I2C controller. Main use is as a bench partner and as an on-chip register-slave endpoint.
- Samples SCL/SDA from the system clock and decodes START, repeated START and STOP.
- Matches a 7-bit address and exposes an 8-bit register-file port with an auto-incrementing register pointer.
- Protocol matches the controller:
  - Write: addr+W, register index, 1..N data bytes.
  - Read: addr+R, then data bytes from the current pointer. No register-index phase on reads.

Parameters:
- TARGET_ADDR, 7'h42, own 7-bit bus address.
- SYNC_STAGES, 2, synchroniser depth on scl_in and sda_in (2 minimum).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL rate.
- rst  in  1  asynchronous, active-high reset.
- scl_in  in  1  SCL pad input. The target never stretches SCL.
- sda_in  in  1  SDA pad input.
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- reg_addr  out  8  current register pointer.
- reg_wdata  out  8  received write byte.
- reg_we  out  1  one-clk write strobe; reg_addr and reg_wdata are valid in the same cycle.
- reg_rdata  in  8  read data for reg_addr; the target samples it combinationally.
- busy  out  1  high from an address match until STOP, or until return to IDLE.

Behaviour:
- Reset values: sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, state=IDLE, shift register=0, bit_cnt=0.
- Input conditioning: SYNC_STAGES flops per line, plus one history flop for edge detection.
- Edge events on synchronised signals:
  - scl_rise / scl_fall: SCL edges.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Timing rules:
  - Data bits are sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall.
- START/STOP priority: these override every other event.
  - START in any state: bit_cnt=0, sda_oe=0, go to ADDR. This covers repeated START.
  - STOP in any state: sda_oe=0, busy=0, go to IDLE.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. Then compare bits[7:1] with TARGET_ADDR.
    - Match: busy=1, drive ACK (sda_oe=1 on the next scl_fall), go to ADDR_ACK. Record the R/W bit.
    - Mismatch: sda_oe stays 0, go to IGNORE.
  - ADDR_ACK: on the scl_fall after the ACK clock, release SDA (sda_oe=0).
    - W: go to REG.
    - R: load the shift register from reg_rdata and drive bit7 (sda_oe = ~bit) in the same cycle. Go to RDATA.
  - REG: shift 8 bits, then reg_addr = byte, ACK, go to REG_ACK, then WDATA.
  - WDATA: shift 8 bits. On the 8th scl_rise + 1 clk: reg_wdata = byte, reg_we pulses for 1 clk, ACK. After the ACK clock, reg_addr increments by 1, wrapping 8'hFF -> 8'h00. Go back to WDATA.
  - RDATA: shift bits out on each scl_fall; release SDA after bit0. On the 9th scl_rise, sample the controller's ACK.
    - ACK (SDA=0): reg_addr += 1 (wrapping), reload from reg_rdata, continue RDATA.
    - NACK: reg_addr += 1, go to IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Register pointer: persists across transactions and is reset only by rst. A read therefore continues from the pointer left by the last write.
- Simultaneous events: START or STOP detected in the same clk as an scl edge is treated as START/STOP only.
- Reset mid-transfer: SDA is released immediately (asynchronous). A partial byte is discarded and reg_we is never pulsed.
- Latency: reg_we fires 1 + SYNC_STAGES clk after the 8th data-bit SCL rise at the pad.

Decomposition:
- Shared package i2c_pkg:
  - State encoding constants.
  - I2C_ACK=1'b0 and I2C_NACK=1'b1.
  - Default address constant.
- Sub-module i2c_bus_monitor: synchronisers plus edge/START/STOP detection. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s. Reusable by a later bus sniffer.

Test Plan:
- Write single byte (TARGET_ADDR=0x42): START, 0x84, reg 0x10, data 0xA5, STOP
  - ACK on all three bytes.
  - One reg_we with reg_addr=0x10, reg_wdata=0xA5.
  - Final reg_addr=0x11, busy=0 after STOP.
- Two-byte write at the wrap point: reg 0xFF, data 0x12 then 0x34
  - reg_we at 0xFF with 0x12, then at 0x00 with 0x34.
- Read after write: bench memory mem[0x20]=0x5A, mem[0x21]=0xC3.
  - Write reg 0x20 with no data, STOP.
  - START, 0x85, controller ACKs byte 1 and NACKs byte 2.
  - SDA carries 0x5A then 0xC3; reg_addr=0x22; SDA released after the NACK.
- Address mismatch: START, 0x86, bytes 0xFF, STOP
  - sda_oe stays 0 throughout; no reg_we; busy stays 0.
- Repeated START mid-byte: after 4 bits of a data byte, START then 0x85
  - No reg_we for the partial byte.
  - Address is ACKed; read returns mem[reg_addr].
- Async reset while sda_oe=1 during an ACK: rst pulse
  - sda_oe=0 in the same cycle; reg_addr=0; state IDLE; next transaction works normally.
